// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared state, class and field encodings for the RV32I multi-cycle sequencer
package ctrl_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [2:0] {R_ALU, I_ALU, LOAD, STORE, BRANCH, ILLEGAL} instr_class_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [1:0] IMM_I     = 2'b00;
    localparam logic [1:0] IMM_S     = 2'b01;
    localparam logic [1:0] IMM_B     = 2'b10;
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [31:0] NOP      = 32'h00000013;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory handshakes and datapath control lines between sequencer and datapath
interface multicycle_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] instr;
    logic                  imem_req;
    logic                  imem_ack;
    logic                  dmem_req;
    logic                  dmem_we;
    logic                  dmem_ack;
    logic                  EQ;
    logic                  PCwrite;
    logic                  PCsrc;
    logic                  RegWrite;
    logic [2:0]            ALUctrl;
    logic                  ALUsrc;
    logic [1:0]            ImmSrc;
    logic                  ResultSrc;
    logic [DATA_WIDTH-1:0] ir_q;
    logic                  trap;
    logic [1:0]            trap_cause;
    modport master (
        input  instr, imem_ack, dmem_ack, EQ,
        output imem_req, dmem_req, dmem_we, PCwrite, PCsrc, RegWrite,
               ALUctrl, ALUsrc, ImmSrc, ResultSrc, ir_q, trap, trap_cause
    );
    modport slave (
        output instr, imem_ack, dmem_ack, EQ,
        input  imem_req, dmem_req, dmem_we, PCwrite, PCsrc, RegWrite,
               ALUctrl, ALUsrc, ImmSrc, ResultSrc, ir_q, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// ctrl_decoder: classifies the latched instruction and derives its static datapath fields
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]   op,
    input  logic [2:0]   f3,
    input  logic [6:0]   f7,
    output instr_class_t cls,
    output logic [2:0]   alu_ctrl,
    output logic         alu_src,
    output logic [1:0]   imm_src,
    output logic         result_src,
    output logic         br_ne
);
    // illegal encodings fall through to ILLEGAL and leave every field at 0
    always_comb begin
        cls = ILLEGAL;
        if (op == OP_R && f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) cls = R_ALU;
        else if (op == OP_IMM && f3 == F3_ADD) cls = I_ALU;
        else if (op == OP_LOAD && f3 == F3_WORD) cls = LOAD;
        else if (op == OP_STORE && f3 == F3_WORD) cls = STORE;
        else if (op == OP_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE)) cls = BRANCH;
        alu_ctrl   = ((cls == R_ALU && f7 == F7_SUB) || cls == BRANCH) ? ALU_SUB : ALU_ADD;
        alu_src    = cls inside {I_ALU, LOAD, STORE};
        imm_src    = cls == STORE ? IMM_S : cls == BRANCH ? IMM_B : IMM_I;
        result_src = cls == LOAD;
        br_ne      = cls == BRANCH && f3 == F3_BNE;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing fetch/decode/exec/mem/wb with wait-timeout and illegal-opcode traps
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input logic clk,
    input logic rst_n,
    multicycle_ctrl_if.master bus
);
    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] ir;
    logic [7:0]            cnt;
    logic [1:0]            cause;
    instr_class_t          cls;
    logic [2:0]            alu_ctrl;
    logic                  alu_src;
    logic [1:0]            imm_src;
    logic                  result_src;
    logic                  br_ne;
    logic                  waiting;
    logic                  ack;
    logic                  timeout;
    logic                  fields;

    ctrl_decoder u_dec (
        .op(ir[6:0]),
        .f3(ir[14:12]),
        .f7(ir[31:25]),
        .cls(cls),
        .alu_ctrl(alu_ctrl),
        .alu_src(alu_src),
        .imm_src(imm_src),
        .result_src(result_src),
        .br_ne(br_ne)
    );

    // the ack that matters is the one for the request this state is issuing; an ack on the last allowed cycle beats the timeout
    always_comb begin
        waiting = state == FETCH || state == MEM;
        ack     = state == FETCH ? bus.imem_ack : bus.dmem_ack;
        timeout = waiting && !ack && cnt == 8'(MAX_WAIT - 1);
    end

    // state register; reset overrides every transition including TRAP
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   state_nx = bus.imem_ack ? DECODE : timeout ? TRAP : FETCH;
            DECODE:  state_nx = cls == ILLEGAL ? TRAP : EXEC;
            EXEC:    state_nx = cls inside {LOAD, STORE} ? MEM : cls == BRANCH ? FETCH : WB;
            MEM:     state_nx = bus.dmem_ack ? (cls == LOAD ? WB : FETCH) : timeout ? TRAP : MEM;
            WB:      state_nx = FETCH;
            TRAP:    state_nx = TRAP;
            default: state_nx = IDLE;
        endcase
    end

    // IR capture, wait counter (restarts whenever a new request state is entered) and trap cause
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir    <= DATA_WIDTH'(NOP);
            cnt   <= '0;
            cause <= CAUSE_NONE;
        end else begin
            if (state == FETCH && bus.imem_ack) ir <= bus.instr;
            cnt <= (waiting && !ack && state_nx == state) ? cnt + 8'd1 : '0;
            if (state_nx == TRAP && state != TRAP) cause <= state == DECODE ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
    end

    // control outputs from registered state and IR; only EQ and dmem_ack reach outputs combinationally
    always_comb begin
        fields         = state inside {DECODE, EXEC, MEM, WB};
        bus.imem_req   = state == FETCH;
        bus.dmem_req   = state == MEM;
        bus.dmem_we    = state == MEM && cls == STORE;
        bus.PCwrite    = (state == EXEC && cls == BRANCH) || (state == MEM && cls == STORE && bus.dmem_ack) || state == WB;
        bus.PCsrc      = state == EXEC && cls == BRANCH && (br_ne ? !bus.EQ : bus.EQ);
        bus.RegWrite   = state == WB;
        bus.ALUctrl    = fields ? alu_ctrl : ALU_ADD;
        bus.ALUsrc     = fields && alu_src;
        bus.ImmSrc     = fields ? imm_src : IMM_I;
        bus.ResultSrc  = fields && result_src;
        bus.ir_q       = ir;
        bus.trap       = state == TRAP;
        bus.trap_cause = cause;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle stimulus with a queued expected-control scoreboard
module tb_multicycle_ctrl;
    typedef struct {
        string       nm;
        logic [15:0] e;
        logic        ck_ir;
        logic [31:0] ir;
    } exp_t;

    localparam logic [5:0] S_NONE  = 6'b000000;
    localparam logic [5:0] S_FETCH = 6'b100000;
    localparam logic [5:0] S_MEMR  = 6'b010000;
    localparam logic [5:0] S_MEMW  = 6'b011000;
    localparam logic [5:0] S_SWACK = 6'b011100;
    localparam logic [5:0] S_WB    = 6'b000101;
    localparam logic [5:0] S_BR1   = 6'b000110;
    localparam logic [5:0] S_BR0   = 6'b000100;
    localparam logic [6:0] F_NONE  = 7'b000_0_00_0;
    localparam logic [6:0] F_LW    = 7'b000_1_00_1;
    localparam logic [6:0] F_BR    = 7'b001_0_10_0;
    localparam logic [6:0] F_ADDI  = 7'b000_1_00_0;
    localparam logic [6:0] F_SW    = 7'b000_1_01_0;
    localparam logic [2:0] T_NONE  = 3'b000;
    localparam logic [2:0] T_ILL   = 3'b101;
    localparam logic [2:0] T_TO    = 3'b110;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic clk = 0;
    logic rst_n = 0;
    int total = 0;
    int bad = 0;
    exp_t q[$];

    multicycle_ctrl_if #(.DATA_WIDTH(32)) bus();
    multicycle_ctrl #(.DATA_WIDTH(32), .MAX_WAIT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] ex(logic [5:0] s, logic [6:0] f, logic [2:0] t);
        return {s, f, t};
    endfunction

    // drive one cycle's inputs just after the edge and queue what the outputs must be in that cycle
    task automatic cyc(string nm, logic rn, logic [31:0] ins, logic ia, logic da, logic eq,
                       logic [15:0] e, logic ck_ir = 1'b0, logic [31:0] ir = 32'h0);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rn;
        bus.instr = ins;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        bus.EQ = eq;
        x.nm = nm;
        x.e = e;
        x.ck_ir = ck_ir;
        x.ir = ir;
        q.push_back(x);
    endtask

    // monitor: every cycle that has an expectation queued is compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [15:0] act;
            x = q.pop_front();
            act = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.PCwrite, bus.PCsrc, bus.RegWrite,
                   bus.ALUctrl, bus.ALUsrc, bus.ImmSrc, bus.ResultSrc, bus.trap, bus.trap_cause};
            total++;
            if (act !== x.e) begin
                bad++;
                $display("FAIL %s: ctrl got=%b expected=%b", x.nm, act, x.e);
            end
            if (x.ck_ir) begin
                total++;
                if (bus.ir_q !== x.ir) begin
                    bad++;
                    $display("FAIL %s ir_q: got=%h expected=%h", x.nm, bus.ir_q, x.ir);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr = 0;
        bus.imem_ack = 0;
        bus.dmem_ack = 0;
        bus.EQ = 0;
        cyc("reset1", 0, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE), 1, 32'h13);
        cyc("reset_idle", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE));
        cyc("add_fetch", 1, I_ADD, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("add_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE), 1, I_ADD);
        cyc("add_exec", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE));
        cyc("add_wb", 1, 0, 0, 0, 0, ex(S_WB, F_NONE, T_NONE));
        cyc("lw_fetch", 1, I_LW, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("lw_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_LW, T_NONE), 1, I_LW);
        cyc("lw_exec", 1, 0, 0, 0, 0, ex(S_NONE, F_LW, T_NONE));
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1, 0, 0, 0, 0, ex(S_MEMR, F_LW, T_NONE));
        cyc("lw_mem_ack", 1, 0, 0, 1, 0, ex(S_MEMR, F_LW, T_NONE));
        cyc("lw_wb", 1, 0, 0, 0, 0, ex(S_WB, F_LW, T_NONE));
        cyc("bne_fetch", 1, I_BNE, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("bne_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_BR, T_NONE), 1, I_BNE);
        cyc("bne_exec_ne", 1, 0, 0, 0, 0, ex(S_BR1, F_BR, T_NONE));
        cyc("bne2_fetch", 1, I_BNE, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("bne2_decode", 1, 0, 0, 0, 1, ex(S_NONE, F_BR, T_NONE));
        cyc("bne2_exec_eq", 1, 0, 0, 0, 1, ex(S_BR0, F_BR, T_NONE));
        cyc("addi_fetch", 1, I_ADDI, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("addi_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_ADDI, T_NONE));
        cyc("addi_exec", 1, 0, 0, 0, 0, ex(S_NONE, F_ADDI, T_NONE));
        cyc("addi_wb", 1, 0, 0, 0, 0, ex(S_WB, F_ADDI, T_NONE));
        cyc("sw_fetch", 1, I_SW, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("sw_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_SW, T_NONE));
        cyc("sw_exec", 1, 0, 0, 0, 0, ex(S_NONE, F_SW, T_NONE));
        for (int i = 0; i < 14; i++) cyc("sw_mem_wait", 1, 0, 0, 0, 0, ex(S_MEMW, F_SW, T_NONE));
        cyc("sw_ack_at_limit", 1, 0, 0, 1, 0, ex(S_SWACK, F_SW, T_NONE));
        cyc("sw2_fetch", 1, I_SW, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("sw2_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_SW, T_NONE));
        cyc("sw2_exec", 1, 0, 0, 0, 0, ex(S_NONE, F_SW, T_NONE));
        cyc("sw2_mem", 1, 0, 0, 0, 0, ex(S_MEMW, F_SW, T_NONE));
        cyc("sw2_mem_rst", 0, 0, 0, 0, 0, ex(S_MEMW, F_SW, T_NONE));
        cyc("sw2_after_rst", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE));
        cyc("sw3_fetch", 1, I_SW, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("sw3_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_SW, T_NONE));
        cyc("sw3_exec", 1, 0, 0, 0, 0, ex(S_NONE, F_SW, T_NONE));
        for (int i = 0; i < 15; i++) cyc("sw3_mem_wait", 1, 0, 0, 0, 0, ex(S_MEMW, F_SW, T_NONE));
        cyc("timeout_trap", 1, 0, 1, 1, 0, ex(S_NONE, F_NONE, T_TO));
        cyc("timeout_hold", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_TO));
        cyc("timeout_rst", 0, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_TO));
        cyc("ill_idle", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE));
        cyc("ill_fetch", 1, I_BAD, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("ill_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE), 1, I_BAD);
        cyc("ill_trap", 1, I_ADD, 1, 0, 0, ex(S_NONE, F_NONE, T_ILL));
        cyc("ill_trap_acks", 1, I_ADD, 1, 1, 0, ex(S_NONE, F_NONE, T_ILL));
        cyc("ill_trap_rst", 0, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_ILL));
        cyc("post_idle", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE), 1, 32'h13);
        cyc("fetch_spur_dack", 1, 0, 0, 1, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("fetch_late_ack", 1, I_ADD, 1, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        cyc("add2_decode", 1, 0, 0, 0, 0, ex(S_NONE, F_NONE, T_NONE));
        cyc("add2_exec_spur", 1, I_BAD, 1, 1, 0, ex(S_NONE, F_NONE, T_NONE));
        cyc("add2_wb", 1, 0, 0, 0, 0, ex(S_WB, F_NONE, T_NONE), 1, I_ADD);
        cyc("add2_next_fetch", 1, 0, 0, 0, 0, ex(S_FETCH, F_NONE, T_NONE));
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath (register file, ALU, immediate generator, PC, instruction and data memory ports).
- Fetches each instruction over an instruction-memory req/ack handshake and latches it into an internal IR.
- Decodes the IR, then steps the datapath through EXEC, MEM and WB states.
- Holds every datapath control line stable for the whole instruction, and traps on illegal opcodes or memory timeouts.

Parameters:
- DATA_WIDTH, 32, instruction and data word width.
- MAX_WAIT, 15, maximum cycles a memory request may stay unacknowledged before a timeout trap; range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- instr  in  DATA_WIDTH  instruction word from imem; valid when imem_ack=1.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; instr is valid.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable; only meaningful with dmem_req.
- dmem_ack  in  1  data access complete.
- EQ  in  1  ALU equality flag.
- PCwrite  out  1  PC update strobe.
- PCsrc  out  1  0 = PC+4, 1 = PC+immB.
- RegWrite  out  1  register file write enable.
- ALUctrl  out  3  000 add, 001 sub.
- ALUsrc  out  1  0 = rs2, 1 = immediate.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type.
- ResultSrc  out  1  0 = ALU result, 1 = memory read data.
- ir_q  out  DATA_WIDTH  latched instruction, to the regfile address and immediate generator.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 illegal instruction, 10 memory timeout.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ir_q=32'h00000013, wait counter=0, trap=0, trap_cause=00.
  - All outputs are 0.
  - Reset wins over every other event, including mid-MEM and in TRAP.
- Supported instructions:
  - add: op 0110011, f3 000, f7 0000000.
  - sub: op 0110011, f3 000, f7 0100000.
  - addi: op 0010011, f3 000.
  - lw: op 0000011, f3 010.
  - sw: op 0100011, f3 010.
  - beq: op 1100011, f3 000.
  - bne: op 1100011, f3 001.
  - Any other encoding is illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded from the registered state plus ir_q; no input-to-output combinational paths except PCwrite in MEM and PCsrc in EXEC.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - imem_req=1.
  - On imem_ack=1 at the edge, ir_q<=instr and go to DECODE; otherwise stay.
- DECODE: one cycle. Illegal encoding -> TRAP with cause 01. Otherwise go to EXEC.
- Field validity: ALUctrl, ALUsrc, ImmSrc and ResultSrc are valid from DECODE until the instruction's final cycle, and 0 in IDLE, FETCH and TRAP.
- EXEC:
  - add/sub/addi -> WB.
  - lw/sw -> MEM.
  - beq/bne: EQ is sampled here only. PCwrite=1; PCsrc=1 iff (beq and EQ) or (bne and !EQ); then go to FETCH.
- MEM:
  - dmem_req=1, dmem_we=1 for sw.
  - On dmem_ack: lw goes to WB; sw asserts PCwrite=1 (PCsrc=0) in that same ack cycle and goes to FETCH.
- WB: RegWrite=1, PCwrite=1, PCsrc=0, ResultSrc=1 for lw; then go to FETCH.
- Strobe rules:
  - PCwrite is exactly one cycle per retired instruction.
  - RegWrite is exactly one cycle, and never in the same instruction as dmem_we.
- Latency with zero-wait memory (ack in the first req cycle):
  - Branch: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait state adds 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle req is high without ack.
  - When it reaches MAX_WAIT without ack, the next state is TRAP with cause 10.
  - An ack in the same cycle the counter hits MAX_WAIT wins; no trap is raised.
- TRAP:
  - trap=1, trap_cause held, all other outputs 0.
  - Stays in TRAP until reset; acks received while in TRAP are ignored.
- Spurious acks: imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Reset mid-operation: state goes to IDLE, no PCwrite or RegWrite is issued, and a pending request drops in the cycle after the reset edge.

Decomposition:
- ctrl_pkg holds:
  - state_t enum.
  - Opcode, funct3 and funct7 constants.
  - ALUctrl encodings (ALU_ADD, ALU_SUB).
  - ImmSrc encodings (IMM_I, IMM_S, IMM_B).
  - Trap cause codes.
  - instr_class_t enum: R_ALU, I_ALU, LOAD, STORE, BRANCH, ILLEGAL.
- ctrl_decoder is a combinational sub-module. It maps ir_q to instr_class_t plus the static fields (ALUctrl, ALUsrc, ImmSrc, ResultSrc, branch polarity).
- multicycle_ctrl contains the FSM, IR register, wait counter and trap registers.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> all outputs 0 during reset; IDLE for 1 cycle; imem_req=1 on the 2nd cycle after release.
- add x3,x1,x2 (32'h002081B3) with immediate ack -> DECODE/EXEC/WB follow; ALUctrl=000, ALUsrc=0; RegWrite and PCwrite=1 only in WB; next imem_req exactly 4 cycles after the first.
- lw (32'h0000A183) with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0; WB has ResultSrc=1 and RegWrite=1; total 8 cycles.
- bne (32'h00209463), first with EQ=0 -> PCwrite=1 and PCsrc=1 in EXEC; repeat with EQ=1 -> PCsrc=0; RegWrite stays 0 in both.
- Illegal 32'hFFFFFFFF -> TRAP after DECODE, trap_cause=01, all strobes 0; further imem_ack pulses ignored until rst_n=0.
- sw with dmem_ack withheld and MAX_WAIT=15 -> trap_cause=10 after 15 req cycles. Repeat with ack arriving on cycle 15 -> no trap, PCwrite pulses. Repeat with rst_n low mid-MEM -> IDLE, no PCwrite.
